nes_mem_arbiter: RTL and testbench

Sequencer that shares the single SDRAM controller port between the game loader (ROM write stream from flash) and the NES core (CPU/PPU reads, CPU writes). Replaces the open-coded `load_done` muxing and single-entry loader latch in the top level. Buffers loader bytes in a small FIFO, issues them one per NES slot aligned to the `nes_ce` phase, drains the buffer before releasing the NES from hold, and passes the NES request set through once running.

---
 rtl/nes_mem_arbiter_if.sv | 37 +++
 rtl/nes_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_nes_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_mem_arbiter_if.sv
// Bus bundle between the NES memory arbiter, the game loader, the NES core and the SDRAM port.
// "slave" is the arbiter's view; "master" is the surrounding top level / testbench view.
interface nes_mem_arbiter_if #(
  parameter int ADDR_W = 22
);
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;
  logic              ld_ready;

  logic [ADDR_W-1:0] nes_addr;
  logic              nes_read_cpu;
  logic              nes_read_ppu;
  logic              nes_write;
  logic [7:0]        nes_dout;

  logic [24:0]       sd_addr;
  logic              sd_we;
  logic [7:0]        sd_din;
  logic              sd_oe_a;
  logic              sd_oe_b;
  logic              sd_drive;

  modport slave (
    input  ld_valid, ld_addr, ld_data,
    output ld_ready,
    input  nes_addr, nes_read_cpu, nes_read_ppu, nes_write, nes_dout,
    output sd_addr, sd_we, sd_din, sd_oe_a, sd_oe_b, sd_drive
  );

  modport master (
    output ld_valid, ld_addr, ld_data,
    input  ld_ready,
    output nes_addr, nes_read_cpu, nes_read_ppu, nes_write, nes_dout,
    input  sd_addr, sd_we, sd_din, sd_oe_a, sd_oe_b, sd_drive
  );
endinterface

// File: rtl/nes_mem_arbiter.sv
// Shares the SDRAM port between the loader write stream (FIFO-buffered, one write per nes_ce slot)
// and the NES core. Optional macro NES_ARB_WRCOUNT_EN enables the saturating wr_count counter.
module nes_mem_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 22
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        ce_phase,
  input  logic              load_done,
  nes_mem_arbiter_if.slave  bus,
  output logic              nes_hold,
  output logic              overflow,
  output logic [ADDR_W-1:0] wr_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {LOAD, DRAIN, RUN} state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              sd_we_q, sd_we_d;
  logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
  logic [7:0]        sd_din_q, sd_din_d;
  logic              overflow_q, overflow_d;

  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [7:0]        data_mem [FIFO_DEPTH];

  logic empty, full, slot, loading, push, pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign slot    = (ce_phase == 2'd3);
  assign loading = (state_q != RUN);
  // Full is judged on registered occupancy, so a push coinciding with a pop while full is dropped.
  assign push    = loading & bus.ld_valid & ~full;
  assign pop     = loading & slot & ~empty;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    sd_we_d    = sd_we_q;
    sd_addr_d  = sd_addr_q;
    sd_din_d   = sd_din_q;
    overflow_d = overflow_q | (loading & bus.ld_valid & full);

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      sd_we_d   = 1'b1;
      sd_addr_d = addr_mem[rd_ptr_q];
      sd_din_d  = data_mem[rd_ptr_q];
    end else if (loading && slot) begin
      sd_we_d = 1'b0;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A push landing in the same cycle as "empty" keeps us loading so that byte is not stranded.
    unique case (state_q)
      LOAD: begin
        if (load_done) begin
          if (!empty)                   state_d = DRAIN;
          else if (!sd_we_q && !push)   state_d = RUN;
        end
      end
      DRAIN: begin
        if (slot && empty && !push) state_d = RUN;
      end
      RUN: begin
        if (!load_done) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q    <= LOAD;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sd_we_q    <= 1'b0;
      sd_addr_q  <= '0;
      sd_din_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sd_we_q    <= sd_we_d;
      sd_addr_q  <= sd_addr_d;
      sd_din_q   <= sd_din_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; entries are only read when count_q says they are valid.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= bus.ld_addr;
      data_mem[wr_ptr_q] <= bus.ld_data;
    end
  end

`ifdef NES_ARB_WRCOUNT_EN
  logic [ADDR_W-1:0] wr_count_q, wr_count_d;

  always_comb begin
    wr_count_d = wr_count_q;
    if (pop && (wr_count_q != '1)) wr_count_d = wr_count_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) wr_count_q <= '0;
    else       wr_count_q <= wr_count_d;
  end

  assign wr_count = wr_count_q;
`else
  assign wr_count = '0;
`endif

  always_comb begin
    if (state_q == RUN) begin
      bus.sd_addr = 25'(bus.nes_addr);
      bus.sd_we   = bus.nes_write;
      bus.sd_din  = bus.nes_dout;
      bus.sd_oe_a = bus.nes_read_cpu;
      bus.sd_oe_b = bus.nes_read_ppu;
    end else begin
      bus.sd_addr = 25'(sd_addr_q);
      bus.sd_we   = sd_we_q;
      bus.sd_din  = sd_din_q;
      bus.sd_oe_a = 1'b0;
      bus.sd_oe_b = 1'b0;
    end
  end

  assign bus.sd_drive = bus.sd_we;
  assign bus.ld_ready = ~full;
  assign nes_hold     = (state_q != RUN) | ~load_done;
  assign overflow     = overflow_q;
endmodule

// File: tb/tb_nes_mem_arbiter.sv
// Directed bench for nes_mem_arbiter: reset, slot-aligned loader writes, overflow, drain, RUN pass-through,
// reload and asynchronous reset mid-slot.
module tb_nes_mem_arbiter;
  localparam int ADDR_W = 22;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        ce_phase;
  logic              load_done;
  logic              nes_hold;
  logic              overflow;
  logic [ADDR_W-1:0] wr_count;

  int checks = 0;
  int errors = 0;

  nes_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  nes_mem_arbiter #(.FIFO_DEPTH(4), .ADDR_W(ADDR_W)) dut (
    .clock     (clk),
    .reset     (reset),
    .ce_phase  (ce_phase),
    .load_done (load_done),
    .bus       (bus),
    .nes_hold  (nes_hold),
    .overflow  (overflow),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, want completion)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [21:0] addr;
    logic        cpu;
    logic        ppu;
    logic        wr;
    logic [7:0]  dout;
    logic [24:0] e_addr;
    logic        e_we;
    logic        e_oea;
    logic        e_oeb;
    logic [7:0]  e_din;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One clock; ce_phase advances right after the edge the DUT just sampled.
  task automatic cycle();
    @(posedge clk);
    #1;
    ce_phase = ce_phase + 2'd1;
    #1;
  endtask

  task automatic wait_phase(input logic [1:0] p);
    for (int i = 0; i < 4 && ce_phase != p; i++) cycle();
  endtask

  // Runs up to and including the next slot-boundary edge.
  task automatic to_slot();
    wait_phase(2'd3);
    cycle();
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    ce_phase         = 2'd0;
    load_done        = 1'b0;
    bus.ld_valid     = 1'b0;
    bus.ld_addr      = '0;
    bus.ld_data      = '0;
    bus.nes_addr     = '0;
    bus.nes_read_cpu = 1'b0;
    bus.nes_read_ppu = 1'b0;
    bus.nes_write    = 1'b0;
    bus.nes_dout     = '0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    // ---- reset values
    do_reset();
    reset = 1'b1;
    #1;
    check("rst_sd_we",    bus.sd_we,    0);
    check("rst_sd_addr",  bus.sd_addr,  0);
    check("rst_sd_din",   bus.sd_din,   0);
    check("rst_oe",       {bus.sd_oe_a, bus.sd_oe_b}, 0);
    check("rst_overflow", overflow,     0);
    check("rst_wr_count", wr_count,     0);
    check("rst_nes_hold", nes_hold,     1);
    check("rst_ld_ready", bus.ld_ready, 1);
    reset = 1'b0;

    // ---- single byte pushed at phase 1, issued after the phase-3 edge for four clocks
    do_reset();
    wait_phase(2'd1);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 22'h000010;
    bus.ld_data  = 8'hA5;
    cycle();
    bus.ld_valid = 1'b0;
    check("t1_pre_we", bus.sd_we, 0);
    cycle();
    check("t1_pre_we2", bus.sd_we, 0);
    cycle();
    check("t1_we",   bus.sd_we,   1);
    check("t1_addr", bus.sd_addr, 25'h0000010);
    check("t1_din",  bus.sd_din,  8'hA5);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t1_we_hold", bus.sd_we, 1);
    end
    cycle();
    check("t1_we_end",  bus.sd_we,  0);
    check("t1_din_end", bus.sd_din, 8'hA5);

    // ---- six consecutive pushes starting on a slot edge: 4 fill, 5th dropped (full), 6th fits after a pop
    do_reset();
    wait_phase(2'd3);
    for (int i = 0; i < 6; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 22'h000100 + 22'(i);
      bus.ld_data  = 8'h30 + 8'(i);
      cycle();
      if (i == 2) check("t2_ready_3", bus.ld_ready, 1);
      if (i == 3) begin
        check("t2_ready_full", bus.ld_ready, 0);
        check("t2_no_ovf_yet", overflow, 0);
        check("t2_we_idle", bus.sd_we, 0);
      end
      if (i == 4) begin
        check("t2_overflow", overflow, 1);
        check("t2_we0",  bus.sd_we,  1);
        check("t2_din0", bus.sd_din, 8'h30);
      end
    end
    bus.ld_valid = 1'b0;
    begin
      logic [7:0] exp_din [4];
      exp_din = '{8'h31, 8'h32, 8'h33, 8'h35};
      for (int k = 0; k < 4; k++) begin
        to_slot();
        check("t2_we",  bus.sd_we,  1);
        check("t2_din", bus.sd_din, exp_din[k]);
      end
    end
    check("t2_last_addr", bus.sd_addr, 25'h0000105);
    to_slot();
    check("t2_we_end", bus.sd_we, 0);
    check("t2_overflow_sticky", overflow, 1);

    // ---- three bytes, load_done next clock: drain through three slots, then RUN
    do_reset();
    wait_phase(2'd0);
    for (int i = 0; i < 3; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 22'h000200 + 22'(i);
      bus.ld_data  = 8'h60 + 8'(i);
      cycle();
    end
    bus.ld_valid = 1'b0;
    load_done    = 1'b1;
    cycle();
    check("t3_hold_d1", nes_hold, 1);
    check("t3_din1",    bus.sd_din, 8'h60);
    to_slot();
    check("t3_hold_d2", nes_hold, 1);
    check("t3_din2",    bus.sd_din, 8'h61);
    to_slot();
    check("t3_hold_d3", nes_hold, 1);
    check("t3_din3",    bus.sd_din, 8'h62);
    check("t3_we3",     bus.sd_we,  1);
    wait_phase(2'd3);
    check("t3_hold_pre", nes_hold, 1);
    cycle();
    check("t3_hold_run", nes_hold, 0);
`ifdef NES_ARB_WRCOUNT_EN
    check("t3_wr_count", wr_count, 3);
`else
    check("t3_wr_count", wr_count, 0);
`endif

    // ---- RUN pass-through, zero latency
    vecs[0] = '{22'h012345, 1'b0, 1'b1, 1'b0, 8'h00, 25'h0012345, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[1] = '{22'h3FFFFF, 1'b1, 1'b0, 1'b0, 8'h5A, 25'h03FFFFF, 1'b0, 1'b1, 1'b0, 8'h5A};
    vecs[2] = '{22'h000001, 1'b0, 1'b0, 1'b1, 8'hC3, 25'h0000001, 1'b1, 1'b0, 1'b0, 8'hC3};
    vecs[3] = '{22'h2AAAAA, 1'b0, 1'b0, 1'b0, 8'hFF, 25'h02AAAAA, 1'b0, 1'b0, 1'b0, 8'hFF};
    for (int v = 0; v < 4; v++) begin
      bus.nes_addr     = vecs[v].addr;
      bus.nes_read_cpu = vecs[v].cpu;
      bus.nes_read_ppu = vecs[v].ppu;
      bus.nes_write    = vecs[v].wr;
      bus.nes_dout     = vecs[v].dout;
      #1;
      check("run_addr",  bus.sd_addr,  vecs[v].e_addr);
      check("run_we",    bus.sd_we,    vecs[v].e_we);
      check("run_drive", bus.sd_drive, vecs[v].e_we);
      check("run_oe_a",  bus.sd_oe_a,  vecs[v].e_oea);
      check("run_oe_b",  bus.sd_oe_b,  vecs[v].e_oeb);
      check("run_din",   bus.sd_din,   vecs[v].e_din);
    end

    // ---- reload: load_done falls in RUN
    bus.nes_write    = 1'b0;
    bus.nes_read_ppu = 1'b1;
    load_done        = 1'b0;
    #1;
    check("t5_hold_now", nes_hold, 1);
    cycle();
    check("t5_hold_load", nes_hold, 1);
    check("t5_oe_b_load", bus.sd_oe_b, 0);
    check("t5_we_load",   bus.sd_we, 0);
    bus.nes_read_ppu = 1'b0;

    // ---- async reset mid-slot with one byte still buffered
    wait_phase(2'd2);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 22'h000300;
    bus.ld_data  = 8'h77;
    cycle();
    bus.ld_addr  = 22'h000301;
    bus.ld_data  = 8'h88;
    cycle();
    bus.ld_valid = 1'b0;
    check("t6_we_pre", bus.sd_we, 1);
    check("t6_din_pre", bus.sd_din, 8'h77);
    cycle();
    reset = 1'b1;
    #1;
    check("t6_we_rst",    bus.sd_we,    0);
    check("t6_addr_rst",  bus.sd_addr,  0);
    check("t6_din_rst",   bus.sd_din,   0);
    check("t6_hold_rst",  nes_hold,     1);
    check("t6_ready_rst", bus.ld_ready, 1);
    cycle();
    reset = 1'b0;
    to_slot();
    check("t6_fifo_empty", bus.sd_we, 0);

    // ---- empty FIFO, idle port: load_done goes straight to RUN
    load_done        = 1'b1;
    bus.nes_read_cpu = 1'b1;
    bus.nes_addr     = 22'h00ABCD;
    cycle();
    check("t7_hold_run", nes_hold,    0);
    check("t7_oe_a",     bus.sd_oe_a, 1);
    check("t7_addr",     bus.sd_addr, 25'h000ABCD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
